extensor_imediato_fifo: RTL and testbench

//  Parametrised immediate-extension unit between the decoder and the ULA operand mux.

---
 rtl/extensor_pkg.sv | 16 +
 rtl/extensor_imediato_fifo_fila_saida.sv | 105 ++++++++++
 rtl/extensor_imediato_fifo.sv | 130 +++++++++++++
 tb/tb_extensor_imediato_fifo.sv | 210 +++++++++++++++++++++
 4 files changed

// File: rtl/extensor_pkg.sv
// Shared constants for the immediate-extension unit.
//   - modo encodings seen on the decoder interface
//   - states of the prefix sequencer (used only when EXTENSOR_PREFIXO_EN is defined)
package extensor_pkg;

    localparam logic [1:0] MODO_SINAL   = 2'b00;
    localparam logic [1:0] MODO_ZERO    = 2'b01;
    localparam logic [1:0] MODO_PREFIXO = 2'b10;
    localparam logic [1:0] MODO_RES     = 2'b11;

    typedef enum logic {
        OCIOSO  = 1'b0,
        PREFIXO = 1'b1
    } estado_t;

endpackage

// File: rtl/extensor_imediato_fifo_fila_saida.sv
// fila_saida: PROF x LARG output queue with wrap-around pointers.
// The queue head is kept in its own register so the output is registered
// and simply holds its last value once the queue drains.
// Ports:
//   clock, reset_n   rising-edge clock, asynchronous active-low reset
//   push, dado       write request and data (ignored when full)
//   pop              read request (ignored when empty)
//   cabeca           registered queue head
//   valido           queue non-empty
//   pronta           registered "not full", forced low during reset
module fila_saida #(
    parameter int LARG = 8,
    parameter int PROF = 2
) (
    input  logic            clock,
    input  logic            reset_n,
    input  logic            push,
    input  logic [LARG-1:0] dado,
    input  logic            pop,
    output logic [LARG-1:0] cabeca,
    output logic            valido,
    output logic            pronta
);

    localparam int PTR_W = (PROF > 1) ? $clog2(PROF) : 1;
    localparam int CNT_W = $clog2(PROF + 1);
    localparam logic [CNT_W-1:0] CHEIO = CNT_W'(PROF);
    localparam logic [CNT_W-1:0] VAZIO = {CNT_W{1'b0}};

    logic [LARG-1:0]  mem_r [PROF];
    logic [PTR_W-1:0] wr_r, rd_r, wr_prox_s, rd_prox_s;
    logic [CNT_W-1:0] cont_r, cont_prox_s;
    logic [LARG-1:0]  cabeca_r, cabeca_prox_s;
    logic             pronta_r;
    logic             push_ok_s, pop_ok_s;

    // Pointer increment that wraps modulo PROF (PROF is a power of two).
    function automatic logic [PTR_W-1:0] inc_ptr(input logic [PTR_W-1:0] p);
        if (PROF == 1) begin
            return {PTR_W{1'b0}};
        end else begin
            return p + PTR_W'(1);
        end
    endfunction

    // Next-state for count, pointers and the head register.
    always_comb begin
        push_ok_s     = push & (cont_r != CHEIO);
        pop_ok_s      = pop & (cont_r != VAZIO);
        wr_prox_s     = push_ok_s ? inc_ptr(wr_r) : wr_r;
        rd_prox_s     = pop_ok_s ? inc_ptr(rd_r) : rd_r;
        cabeca_prox_s = cabeca_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   cont_prox_s = cont_r + CNT_W'(1);
            2'b01:   cont_prox_s = cont_r - CNT_W'(1);
            default: cont_prox_s = cont_r;
        endcase
        // The head register mirrors mem_r[rd_r] whenever the queue is non-empty.
        if (cont_r == VAZIO) begin
            if (push_ok_s) begin
                cabeca_prox_s = dado;
            end else begin
                cabeca_prox_s = cabeca_r;
            end
        end else if (pop_ok_s) begin
            if (cont_r > CNT_W'(1)) begin
                cabeca_prox_s = mem_r[inc_ptr(rd_r)];
            end else if (push_ok_s) begin
                cabeca_prox_s = dado;
            end else begin
                cabeca_prox_s = cabeca_r;
            end
        end else begin
            cabeca_prox_s = cabeca_r;
        end
    end

    // Queue storage, pointers, count and registered status.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < PROF; i++) begin
                mem_r[i] <= {LARG{1'b0}};
            end
            wr_r     <= {PTR_W{1'b0}};
            rd_r     <= {PTR_W{1'b0}};
            cont_r   <= VAZIO;
            cabeca_r <= {LARG{1'b0}};
            pronta_r <= 1'b0;
        end else begin
            if (push_ok_s) begin
                mem_r[wr_r] <= dado;
            end
            wr_r     <= wr_prox_s;
            rd_r     <= rd_prox_s;
            cont_r   <= cont_prox_s;
            cabeca_r <= cabeca_prox_s;
            pronta_r <= (cont_prox_s != CHEIO);
        end
    end

    assign cabeca = cabeca_r;
    assign valido = (cont_r != VAZIO);
    assign pronta = pronta_r;

endmodule

// File: rtl/extensor_imediato_fifo.sv
// extensor_imediato_fifo: extends an IN_W-bit immediate to OUT_W bits (sign or
// zero) and queues results in a DEPTH-entry output queue (fila_saida).
// Optional feature macro: EXTENSOR_PREFIXO_EN -- enables the prefix mode where a
// modo=10 beat stores a high half and the following beat supplies the low half.
// Without it, modo=10 behaves as sign extension and prefixo_pendente is 0.
// Ports:
//   clock, reset_n                       clock, asynchronous active-low reset
//   entrada, modo, entrada_valida        immediate beat in
//   entrada_pronta                       registered "queue not full"
//   resultado, resultado_valido          queue head out
//   resultado_pronto                     consumer takes the head
//   prefixo_pendente                     prefix held, waiting for low half
module extensor_imediato_fifo
    import extensor_pkg::*;
#(
    parameter int IN_W  = 5,
    parameter int OUT_W = 8,
    parameter int DEPTH = 2
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [IN_W-1:0]  entrada,
    input  logic [1:0]       modo,
    input  logic             entrada_valida,
    output logic             entrada_pronta,
    output logic [OUT_W-1:0] resultado,
    output logic             resultado_valido,
    input  logic             resultado_pronto,
    output logic             prefixo_pendente
);

    logic             aceita_s;
    logic             pop_s;
    logic             push_s;
    logic             sinal_s;
    logic [OUT_W-1:0] ext_simples_s;
    logic [OUT_W-1:0] dado_s;
    logic             pronta_s;
    logic             valido_s;

    assign aceita_s = entrada_valida & pronta_s;
    assign pop_s    = valido_s & resultado_pronto;

    // Single-beat extension; only zero mode clears the fill bits (11 acts as 00).
    always_comb begin
        if (modo != MODO_ZERO) begin
            sinal_s = entrada[IN_W-1];
        end else begin
            sinal_s = 1'b0;
        end
        ext_simples_s = {{(OUT_W-IN_W){sinal_s}}, entrada};
    end

`ifdef EXTENSOR_PREFIXO_EN
    estado_t          estado_r, estado_prox_s;
    logic [IN_W-1:0]  prefixo_r, prefixo_prox_s;
    logic [OUT_W-1:0] ext_prefixo_s;

    // Two-beat value: {prefix, low half} extended to max(2*IN_W, OUT_W), low OUT_W kept.
    if (OUT_W <= 2 * IN_W) begin : g_pref_trunc
        assign ext_prefixo_s = OUT_W'({prefixo_r, entrada});
    end else begin : g_pref_ext
        logic sinal_pref_s;
        assign sinal_pref_s  = (modo != MODO_ZERO) ? prefixo_r[IN_W-1] : 1'b0;
        assign ext_prefixo_s = {{(OUT_W-2*IN_W){sinal_pref_s}}, prefixo_r, entrada};
    end

    // Prefix sequencer next-state and queue push decision.
    always_comb begin
        estado_prox_s  = estado_r;
        prefixo_prox_s = prefixo_r;
        push_s         = 1'b0;
        dado_s         = ext_simples_s;
        if (aceita_s) begin
            case (modo)
                MODO_PREFIXO: begin
                    estado_prox_s  = PREFIXO;
                    prefixo_prox_s = entrada;
                end
                default: begin
                    push_s        = 1'b1;
                    estado_prox_s = OCIOSO;
                    if (estado_r == PREFIXO) begin
                        dado_s = ext_prefixo_s;
                    end else begin
                        dado_s = ext_simples_s;
                    end
                end
            endcase
        end else begin
            estado_prox_s = estado_r;
        end
    end

    // Prefix sequencer state and prefix register.
    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            estado_r  <= OCIOSO;
            prefixo_r <= {IN_W{1'b0}};
        end else begin
            estado_r  <= estado_prox_s;
            prefixo_r <= prefixo_prox_s;
        end
    end

    assign prefixo_pendente = (estado_r == PREFIXO);
`else
    assign push_s           = aceita_s;
    assign dado_s           = ext_simples_s;
    assign prefixo_pendente = 1'b0;
`endif

    fila_saida #(
        .LARG (OUT_W),
        .PROF (DEPTH)
    ) u_fila (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push_s),
        .dado    (dado_s),
        .pop     (pop_s),
        .cabeca  (resultado),
        .valido  (valido_s),
        .pronta  (pronta_s)
    );

    assign resultado_valido = valido_s;
    assign entrada_pronta   = pronta_s;

endmodule

// File: tb/tb_extensor_imediato_fifo.sv
// Self-checking bench for extensor_imediato_fifo (IN_W=5, OUT_W=8, DEPTH=2).
// Expected results are queued when a beat is accepted and compared when the
// DUT hands the head to the consumer. Honours EXTENSOR_PREFIXO_EN.
module tb_extensor_imediato_fifo;

    logic       clock;
    logic       reset_n;
    logic [4:0] entrada;
    logic [1:0] modo;
    logic       entrada_valida;
    logic       entrada_pronta;
    logic [7:0] resultado;
    logic       resultado_valido;
    logic       resultado_pronto;
    logic       prefixo_pendente;

    int checks   = 0;
    int failures = 0;

    logic [7:0] esperado_q[$];
    logic       pend_m;
    logic [4:0] pref_m;

    extensor_imediato_fifo #(
        .IN_W  (5),
        .OUT_W (8),
        .DEPTH (2)
    ) dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .entrada          (entrada),
        .modo             (modo),
        .entrada_valida   (entrada_valida),
        .entrada_pronta   (entrada_pronta),
        .resultado        (resultado),
        .resultado_valido (resultado_valido),
        .resultado_pronto (resultado_pronto),
        .prefixo_pendente (prefixo_pendente)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic verificar(input string tag, input logic [31:0] obs, input logic [31:0] esp);
        checks++;
        if (obs !== esp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, esp);
        end
    endtask

    // Reference extension of a single beat: only modo=01 zero-fills.
    function automatic logic [7:0] ext_m(input logic [4:0] e, input logic [1:0] m);
        logic s;
        s = (m == 2'b01) ? 1'b0 : e[4];
        return {{3{s}}, e};
    endfunction

    // Consumer side: the head seen here is taken at the next rising edge.
    always @(negedge clock) begin
        if (reset_n && resultado_valido && resultado_pronto) begin
            if (esperado_q.size() == 0) begin
                verificar("saida_extra", {24'd0, resultado}, 32'hFFFF_FFFF);
            end else begin
                verificar("resultado", {24'd0, resultado}, {24'd0, esperado_q.pop_front()});
            end
        end
    end

    task automatic ciclo();
        @(posedge clock);
        #1;
    endtask

    // Drive one beat for one cycle; model it only if the unit is ready.
    task automatic batida(input logic [4:0] e, input logic [1:0] m);
        logic [9:0] comb;
        entrada        = e;
        modo           = m;
        entrada_valida = 1'b1;
        if (entrada_pronta) begin
`ifdef EXTENSOR_PREFIXO_EN
            if (m == 2'b10) begin
                pend_m = 1'b1;
                pref_m = e;
            end else begin
                comb = {pref_m, e};
                esperado_q.push_back(pend_m ? comb[7:0] : ext_m(e, m));
                pend_m = 1'b0;
            end
`else
            esperado_q.push_back(ext_m(e, m));
`endif
        end
        ciclo();
        entrada_valida = 1'b0;
    endtask

    initial begin
        reset_n          = 1'b0;
        entrada          = 5'd0;
        modo             = 2'b00;
        entrada_valida   = 1'b0;
        resultado_pronto = 1'b1;
        pend_m           = 1'b0;
        pref_m           = 5'd0;

        // Reset state
        #12;
        verificar("rst_valido", {31'd0, resultado_valido}, 32'd0);
        verificar("rst_resultado", {24'd0, resultado}, 32'd0);
        verificar("rst_pronta", {31'd0, entrada_pronta}, 32'd0);
        verificar("rst_pendente", {31'd0, prefixo_pendente}, 32'd0);
        reset_n = 1'b1;
        ciclo();
        verificar("pronta_pos_rst", {31'd0, entrada_pronta}, 32'd1);

        // Sign extension, one-cycle latency
        batida(5'b10110, 2'b00);
        verificar("lat_valido", {31'd0, resultado_valido}, 32'd1);
        verificar("sinal_neg", {24'd0, resultado}, 32'hF6);
        ciclo();

        // Zero extension, positive sign, reserved mode
        batida(5'b10110, 2'b01);
        verificar("zero", {24'd0, resultado}, 32'h16);
        batida(5'b01010, 2'b00);
        verificar("sinal_pos", {24'd0, resultado}, 32'h0A);
        batida(5'b10001, 2'b11);
        verificar("reservado", {24'd0, resultado}, 32'hF1);
        ciclo();
        verificar("vazio", {31'd0, resultado_valido}, 32'd0);

        // Backpressure: queue fills, third beat refused
        resultado_pronto = 1'b0;
        batida(5'h01, 2'b00);
        batida(5'h02, 2'b00);
        verificar("cheio_pronta", {31'd0, entrada_pronta}, 32'd0);
        batida(5'h03, 2'b00);
        verificar("cheio_cabeca", {24'd0, resultado}, 32'h01);
        resultado_pronto = 1'b1;
        ciclo();
        verificar("pronta_volta", {31'd0, entrada_pronta}, 32'd1);
        ciclo();
        ciclo();
        verificar("drenado", {31'd0, resultado_valido}, 32'd0);
        verificar("retem", {24'd0, resultado}, 32'h02);

        // Push and pop together at count=1
        resultado_pronto = 1'b0;
        batida(5'h03, 2'b00);
        resultado_pronto = 1'b1;
        batida(5'h04, 2'b00);
        verificar("pp_valido", {31'd0, resultado_valido}, 32'd1);
        verificar("pp_cabeca", {24'd0, resultado}, 32'h04);
        verificar("pp_pronta", {31'd0, entrada_pronta}, 32'd1);
        ciclo();
        verificar("pp_vazio", {31'd0, resultado_valido}, 32'd0);

        // Prefix sequence
        batida(5'b00011, 2'b10);
`ifdef EXTENSOR_PREFIXO_EN
        verificar("pref_pendente", {31'd0, prefixo_pendente}, 32'd1);
        verificar("pref_sem_saida", {31'd0, resultado_valido}, 32'd0);
        batida(5'b10101, 2'b00);
        verificar("pref_resultado", {24'd0, resultado}, 32'h75);
        verificar("pref_limpo", {31'd0, prefixo_pendente}, 32'd0);
`else
        verificar("pref_off_a", {24'd0, resultado}, 32'h03);
        verificar("pref_off_pend", {31'd0, prefixo_pendente}, 32'd0);
        batida(5'b10101, 2'b00);
        verificar("pref_off_b", {24'd0, resultado}, 32'hF5);
`endif
        ciclo();
        // Prefix overwrite, then zero-mode completion
        batida(5'b00001, 2'b10);
        batida(5'b00010, 2'b10);
        batida(5'b00011, 2'b01);
        ciclo();
        ciclo();

        // Reset mid-operation
        resultado_pronto = 1'b0;
        batida(5'b00111, 2'b00);
        batida(5'b00011, 2'b10);
        #2;
        reset_n = 1'b0;
        #1;
        verificar("arst_valido", {31'd0, resultado_valido}, 32'd0);
        verificar("arst_resultado", {24'd0, resultado}, 32'd0);
        verificar("arst_pendente", {31'd0, prefixo_pendente}, 32'd0);
        verificar("arst_pronta", {31'd0, entrada_pronta}, 32'd0);
        esperado_q.delete();
        pend_m = 1'b0;
        pref_m = 5'd0;
        #3;
        reset_n = 1'b1;
        ciclo();
        resultado_pronto = 1'b1;
        batida(5'b00001, 2'b00);
        verificar("pos_rst", {24'd0, resultado}, 32'h01);
        ciclo();
        ciclo();
        verificar("fila_final", esperado_q.size(), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
